// File: rtl/mem_lsu_if.sv
// Request/response and memory-port bundle between a core-side requester and mem_lsu.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_cen;
  logic [31:0] mem_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata, mem_cen
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata, mem_cen
  );
endinterface

// File: rtl/mem_lsu.sv
// RV32 load/store unit: one outstanding access to a synchronous-read word memory,
// byte-lane write masking/replication and load lane extraction with extension.
module mem_lsu #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  mem_lsu_if.slave  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q, req_in;
  logic [31:0] rdata_q, rdata_nxt;
  logic        err_q, err_nxt;
  logic        f3_ok, misal, req_err, accept;
  logic [31:0] addr_al;
  logic [31:0] load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes;
  logic [NUM_LANES-1:0]      lane_sel;

  // Request decode; funct3[1:0] is the access size (0 byte, 1 half, 2 word)
  always_comb begin
    f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_we;
      default:                f3_ok = 1'b0;
    endcase
    misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    addr_al = bus.req_addr;
    if (bus.req_funct3[1:0] == 2'b01)      addr_al[0]   = 1'b0;
    else if (bus.req_funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
    req_err = !f3_ok || (ERR_ON_MISALIGN && misal);
  end

  assign bus.req_ready = (state == IDLE) && reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_in        = {bus.req_we, bus.req_funct3, addr_al, bus.req_wdata};

  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    case (state)
      IDLE: if (accept) begin
        if (req_err) begin
          state_nxt = RESP;
          rdata_nxt = '0;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: if (req_q.we) begin
        state_nxt = RESP;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
      end else begin
        state_nxt = DATA;
      end
      DATA: begin
        state_nxt = RESP;
        rdata_nxt = load_val;
        err_nxt   = 1'b0;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      if (accept) req_q <= req_in;
    end
  end

  // Load lane extraction
  assign rd_lanes = bus.mem_data;
  always_comb begin
    rd_byte = rd_lanes[req_q.addr[1:0]];
    rd_half = req_q.addr[1] ? bus.mem_data[31:16] : bus.mem_data[15:0];
    case (req_q.funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'b0, rd_byte};
      3'b101:  load_val = {16'b0, rd_half};
      default: load_val = bus.mem_data;
    endcase
  end

  // Store lanes: replicate data across lanes, enable only the addressed ones
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LANE = 2'(l);
    assign wr_lanes[l] = (req_q.funct3[1:0] == 2'b00) ? req_q.wdata[7:0] :
                         (req_q.funct3[1:0] == 2'b01) ? req_q.wdata[8*(l%2) +: 8] :
                                                        req_q.wdata[8*l +: 8];
    assign lane_sel[l] = (req_q.funct3[1:0] == 2'b00) ? (req_q.addr[1:0] == LANE) :
                         (req_q.funct3[1:0] == 2'b01) ? (req_q.addr[1] == LANE[1]) :
                                                        1'b1;
  end

  // Reset gates the strobes combinationally so a reset during ISSUE drops the write
  assign bus.mem_cen   = (state == ISSUE) && reset;
  assign bus.mem_wmask = ((state == ISSUE) && req_q.we && reset) ? lane_sel : '0;
  assign bus.mem_wdata = wr_lanes;
  assign bus.mem_addr  = {req_q.addr[31:2], 2'b00};

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a word-memory model and an expected-response queue.
module tb_mem_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_if bus0();
  mem_lsu_if bus1();

  mem_lsu #(.ERR_ON_MISALIGN(1'b1)) u_dut  (.clk(clk), .reset(reset), .bus(bus0));
  mem_lsu #(.ERR_ON_MISALIGN(1'b0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  int          cen_count = 0;
  logic [3:0]  last_wmask = '0;
  logic [31:0] last_wdata = '0;
  int          total = 0;
  int          passed = 0;

  // Synchronous-read memory models, read-before-write
  always @(posedge clk) begin
    if (bus0.mem_cen) begin
      cen_count++;
      last_wmask = bus0.mem_wmask;
      last_wdata = bus0.mem_wdata;
      bus0.mem_data <= mem0[bus0.mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus0.mem_wmask[b]) mem0[bus0.mem_addr[9:2]][8*b +: 8] = bus0.mem_wdata[8*b +: 8];
    end
    if (bus1.mem_cen) begin
      bus1.mem_data <= mem1[bus1.mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus1.mem_wmask[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] = bus1.mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat, input int hold);
    exp_t e;
    int   lat;
    int   cen0;
    @(negedge clk);
    chk("req_ready idle", 32'(bus0.req_ready), 32'd1);
    bus0.req_valid  = 1'b1;
    bus0.req_we     = we;
    bus0.req_funct3 = f3;
    bus0.req_addr   = addr;
    bus0.req_wdata  = wdata;
    bus0.rsp_ready  = (hold == 0);
    sbq.push_back('{rdata: exp_rd, err: exp_err, lat: exp_lat});
    cen0 = cen_count;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus0.rsp_valid && lat < 20);
    e = sbq.pop_front();
    chk("rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rsp_rdata", bus0.rsp_rdata, e.rdata);
    chk("rsp_err", 32'(bus0.rsp_err), 32'(e.err));
    if (e.err) chk("err no mem_cen", 32'(cen_count - cen0), 32'd0);
    if (hold > 0) begin
      cen0 = cen_count;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("stall rsp_valid", 32'(bus0.rsp_valid), 32'd1);
        chk("stall rsp_rdata", bus0.rsp_rdata, e.rdata);
        chk("stall req_ready", 32'(bus0.req_ready), 32'd0);
      end
      chk("stall no mem_cen", 32'(cen_count - cen0), 32'd0);
      bus0.rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("rsp_valid drop", 32'(bus0.rsp_valid), 32'd0);
    chk("rsp_rdata held", bus0.rsp_rdata, e.rdata);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mem0[64] = 32'h8899AABB;
    mem1[64] = 32'h8899AABB;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = '0;
    bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b1; bus0.mem_data = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0; bus1.rsp_ready = 1'b1; bus1.mem_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(bus0.req_ready), 32'd0);
    chk("rst rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst rsp_rdata", bus0.rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(bus0.rsp_err), 32'd0);
    chk("rst mem_cen", 32'(bus0.mem_cen), 32'd0);
    reset = 1'b1;
    #1 chk("req_ready after rst", 32'(bus0.req_ready), 32'd1);

    // Loads on the reference word
    run(1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0); // LB
    run(1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 3, 0); // LHU
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 3, 0); // LW

    // Byte store into the top lane
    run(1'b1, 3'b000, 32'h103, 32'h00000012, 32'h0, 1'b0, 2, 0);
    chk("SB wmask", 32'(last_wmask), 32'h8);
    chk("SB wdata", last_wdata, 32'h12121212);
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h1299AABB, 1'b0, 3, 0);

    // Errors: misaligned word, illegal funct3 load/store, misaligned half
    run(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0);
    run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
    run(1'b1, 3'b100, 32'h100, 32'h5, 32'h0, 1'b1, 1, 0);
    run(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0);

    // Lane selection and sign handling
    run(1'b0, 3'b001, 32'h102, 32'h0, 32'h00001299, 1'b0, 3, 0); // LH positive
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000012, 1'b0, 3, 0); // LBU
    run(1'b1, 3'b001, 32'h100, 32'h0000BEEF, 32'h0, 1'b0, 2, 0); // SH low half
    chk("SH wmask", 32'(last_wmask), 32'h3);
    chk("SH wdata", last_wdata, 32'hBEEFBEEF);
    run(1'b0, 3'b001, 32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 0); // LH negative
    run(1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFEF, 1'b0, 3, 0); // LB lane 0

    // Response back-pressure
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h1299BEEF, 1'b0, 3, 5);

    // Reset during ISSUE of a word store
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_funct3 = 3'b010;
    bus0.req_addr = 32'h100; bus0.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    @(negedge clk);
    chk("issue mem_cen", 32'(bus0.mem_cen), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst-issue wmask", 32'(bus0.mem_wmask), 32'd0);
    chk("rst-issue mem_cen", 32'(bus0.mem_cen), 32'd0);
    chk("rst-issue req_ready", 32'(bus0.req_ready), 32'd0);
    @(negedge clk);
    chk("rst-issue rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst-issue mem word", mem0[64], 32'h1299BEEF);
    reset = 1'b1;
    #1 chk("req_ready after rst2", 32'(bus0.req_ready), 32'd1);
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'h1299BEEF, 1'b0, 3, 0);

    // Misalignment cleared instead of flagged
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b010; bus1.req_addr = 32'h102;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus1.rsp_valid && lat < 20);
    chk("noerr latency", 32'(lat), 32'd3);
    chk("noerr rsp_rdata", bus1.rsp_rdata, 32'h8899AABB);
    chk("noerr rsp_err", 32'(bus1.rsp_err), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ERR_ON_MISALIGN, default 1: 1 = misaligned access is flagged as an error; 0 = low address bits are forced to natural alignment.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: request offered.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted when req_valid&req_ready.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32 size/sign code.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: aligned, extended load data (0 for stores).
REQ-013 SHALL have port rsp_err, output, 1 bit: misaligned access or illegal funct3.
REQ-014 SHALL have port mem_addr, output, 32 bits: word address, {addr[31:2],2'b00}.
REQ-015 SHALL have port mem_wmask, output, 4 bits: byte write enables.
REQ-016 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-017 SHALL have port mem_cen, output, 1 bit: memory access enable.
REQ-018 SHALL have port mem_data, input, 32 bits: synchronous read data, valid the cycle after mem_cen.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DATA, RESP.
REQ-020 SHALL assert req_ready only in IDLE.
REQ-021 SHALL, in IDLE on acceptance, register we/funct3/addr/wdata.
REQ-022 SHALL, on a legal accepted request, go to ISSUE.
REQ-023 SHALL, on an illegal accepted request, go to RESP with rsp_err=1, and SHALL perform no memory access.
REQ-024 SHALL treat these funct3 codes as legal: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. All others are illegal.
REQ-025 SHALL treat an access as misaligned when it is a halfword with addr[0]=1 or a word with addr[1:0]!=0; misaligned is illegal only when ERR_ON_MISALIGN=1, otherwise the offending address bits are cleared.
REQ-026 SHALL, in ISSUE, drive mem_cen=1 and mem_addr from the registered address.
REQ-027 SHALL, for a store in ISSUE, drive mem_wmask as SB: 1<<addr[1:0]; SH: addr[1]?4'b1100:4'b0011; SW: 4'b1111.
REQ-028 SHALL, for a store in ISSUE, drive mem_wdata as SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-029 SHALL drive mem_wmask=0 and mem_cen=0 in every state other than ISSUE, and for loads.
REQ-030 SHALL, after ISSUE, go to RESP for a store and to DATA for a load.
REQ-031 SHALL, in DATA, select the byte/halfword lane of mem_data by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), register the result into rsp_rdata, then go to RESP.
REQ-032 SHALL, in RESP, hold rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE; acceptance of a new request SHALL occur at the earliest in the following cycle.
REQ-033 SHALL give, with the request accepted at edge T, rsp_valid rising at T+3 for a load, T+2 for a store, and T+1 for an error.
REQ-034 SHALL, when rsp_valid=0, hold rsp_rdata and rsp_err at their last value; SHALL set rsp_rdata=0 for stores and errors.

Reset
REQ-035 SHALL, while reset=0 at a clk edge, set the state to IDLE and set rsp_valid, rsp_err, rsp_rdata and all request registers to 0.
REQ-036 SHALL combinationally force mem_cen=0 and mem_wmask=0 whenever reset=0, so that a reset asserted during ISSUE suppresses the write.
REQ-037 SHALL deassert req_ready while reset=0, and SHALL assert it in the first cycle after reset is released.

Verification
REQ-038 SHALL be verified with memory word 0x100=0x8899AABB: LB @0x101 -> rsp_rdata=0xFFFFFFAA, rsp_err=0, rsp_valid at T+3.
REQ-039 SHALL be verified with the same word: LHU @0x102 -> rsp_rdata=0x00008899; LW @0x100 -> 0x8899AABB.
REQ-040 SHALL be verified with SB @0x103, wdata=0x00000012 -> in ISSUE mem_wmask=4'b1000 and mem_wdata=0x12121212; a subsequent LW @0x100 -> 0x1299AABB.
REQ-041 SHALL be verified with LW @0x102 (ERR_ON_MISALIGN=1) -> rsp_err=1 at T+1 and mem_cen never asserted; with ERR_ON_MISALIGN=0 -> reads 0x100.
REQ-042 SHALL be verified with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, and no mem_cen.
REQ-043 SHALL be verified with reset=0 asserted during ISSUE of SW @0x100 -> mem_wmask=0 in that cycle, the memory word unchanged, and rsp_valid=0 afterwards.
